// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, key-schedule FSM state type.
package aes_pkg;

    localparam int unsigned NK = 4;
    localparam int unsigned NB = 4;
    localparam int unsigned NR = 10;

    // Round keys held by the schedule: the cipher key plus one per round.
    localparam int unsigned ROUND_KEYS = NR + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } ks_state_t;

    // Rcon[i] for i = 1..10; index 0 and 11..15 pad the table to a full 4-bit index.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_pkg::*;

    // Table lookup into the shared S-box
    always_comb begin
        y = sbox_lookup(a);
    end

endmodule

// File: rtl/key_schedule.sv
// AES-128 key expansion: one round key per cycle into an 11-entry register store.
module key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ks_state_t    state;
    logic [127:0] store [ROUND_KEYS];

    logic [3:0]   next_round;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3, t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    // key_out always holds round key key_round, so it is the source for the next one
    always_comb begin
        next_round = key_round + 4'd1;
        w0         = key_out[127:96];
        w1         = key_out[95:64];
        w2         = key_out[63:32];
        w3         = key_out[31:0];
        rot_w3     = {w3[23:0], w3[31:24]};
        t_word     = sub_w3 ^ {RCON[next_round], 24'h0};
        n0         = w0 ^ t_word;
        n1         = w1 ^ n0;
        n2         = w2 ^ n1;
        n3         = w3 ^ n2;
        next_key   = {n0, n1, n2, n3};
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_subword
            aes_sbox u_sbox (
                .a (rot_w3[8*g +: 8]),
                .y (sub_w3[8*g +: 8])
            );
        end
    endgenerate

    // Control FSM with registered outputs and the round-key store
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_out   <= '0;
            key_round <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int unsigned i = 0; i < ROUND_KEYS; i++) begin
                store[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    key_valid <= 1'b0;
                    if (start) begin
                        store[0]  <= key_in;
                        key_out   <= key_in;
                        key_round <= '0;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    store[next_round] <= next_key;
                    key_out           <= next_key;
                    key_round         <= next_round;
                    key_valid         <= 1'b1;
                    if (next_round == LAST_ROUND) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational read port; indices past the last round read as zero
    always_comb begin
        rd_key = '0;
        if (rd_idx <= LAST_ROUND) begin
            rd_key = store[rd_idx];
        end
    end

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule against a FIPS-197 style reference model.
module tb_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         busy;
    logic         done;

    key_schedule #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned  n_total = 0;
    int unsigned  n_pass  = 0;
    logic [7:0]   sb [256];
    logic [127:0] exp_keys [11];
    logic [127:0] store_m  [11];

    localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ALT   = 128'h000102030405060708090a0b0c0d0e0f;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            end
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-array expansion w[0..43] with running Rcon doubling
    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int j = 0; j < 4; j++) w[j] = k[127 - 32*j -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]};
                temp = temp ^ {rc, 24'h0};
                rc   = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_store_model();
        for (int i = 0; i < 11; i++) store_m[i] = '0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("%s rd_key[%0d]", tag, i), rd_key, (i <= 10) ? store_m[i] : 128'h0);
        end
    endtask

    // One full expansion; key_in is scrambled after the start edge, optional re-pulses of start
    task automatic run_expansion(input string tag, input logic [127:0] k, input bit repulse);
        expand_model(k);
        start  = 1'b1;
        key_in = k;
        tick();
        check({tag, " r0 key_out"}, key_out, k);
        check({tag, " r0 round"}, 128'(key_round), 128'd0);
        check({tag, " r0 valid"}, 128'(key_valid), 128'd1);
        check({tag, " r0 busy"}, 128'(busy), 128'd1);
        check({tag, " r0 done"}, 128'(done), 128'd0);
        store_m[0] = k;
        start  = 1'b0;
        key_in = rand128();
        for (int i = 1; i <= 10; i++) begin
            if (repulse && (i == 3 || i == 5)) begin
                start  = 1'b1;
                key_in = ~k;
            end
            tick();
            start = 1'b0;
            store_m[i] = exp_keys[i];
            check($sformatf("%s r%0d key_out", tag, i), key_out, exp_keys[i]);
            check($sformatf("%s r%0d round", tag, i), 128'(key_round), 128'(i));
            check($sformatf("%s r%0d valid", tag, i), 128'(key_valid), 128'd1);
            check($sformatf("%s r%0d busy", tag, i), 128'(busy), (i < 10) ? 128'd1 : 128'd0);
            check($sformatf("%s r%0d done", tag, i), 128'(done), (i == 10) ? 128'd1 : 128'd0);
            rd_idx = 4'(i);
            #1;
            check($sformatf("%s r%0d store", tag, i), rd_key, exp_keys[i]);
            if (i < 10) begin
                rd_idx = 4'(i + 1);
                #1;
                check($sformatf("%s r%0d stale", tag, i), rd_key, store_m[i+1]);
            end
        end
        tick();
        check({tag, " post valid"}, 128'(key_valid), 128'd0);
        check({tag, " post done"}, 128'(done), 128'd1);
        check({tag, " post busy"}, 128'(busy), 128'd0);
        check({tag, " post key_out"}, key_out, exp_keys[10]);
        check({tag, " post round"}, 128'(key_round), 128'd10);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 128'(busy), 128'd0);
        check({tag, " done"}, 128'(done), 128'd0);
        check({tag, " valid"}, 128'(key_valid), 128'd0);
        check({tag, " round"}, 128'(key_round), 128'd0);
        check({tag, " key_out"}, key_out, 128'h0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rd_idx = '0;
        build_sbox();
        tick();
        tick();
        check_idle("reset");
        clear_store_model();
        sweep("reset");
        rst = 1'b0;
        tick();

        // FIPS-197 appendix key, with spec constants read back
        run_expansion("fips", K_FIPS, 1'b0);
        rd_idx = 4'd1; #1; check("fips const r1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10; #1; check("fips const r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sweep("fips");

        // Restart from DONE with an all-zero key; stale entries overwritten in order
        run_expansion("zero", 128'h0, 1'b0);
        rd_idx = 4'd1; #1; check("zero const r1", rd_key, 128'h62636363626363636263636362636363);
        rd_idx = 4'd10; #1; check("zero const r10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // start pulses during EXPAND are ignored
        run_expansion("repulse", K_FIPS, 1'b1);
        sweep("repulse");

        // Reset in the middle of an expansion
        expand_model(K_ALT);
        start = 1'b1; key_in = K_ALT;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("midrst r%0d key_out", i), key_out, exp_keys[i]);
        end
        rst = 1'b1;
        tick();
        check_idle("midrst");
        clear_store_model();
        sweep("midrst");
        rst = 1'b0;
        tick();
        run_expansion("after_rst", K_FIPS, 1'b0);

        // rst wins over a simultaneous start
        rst = 1'b1; start = 1'b1; key_in = K_ALT;
        tick();
        rst = 1'b0; start = 1'b0;
        check_idle("rst_start");
        clear_store_model();
        tick();
        check_idle("rst_start idle");

        // Randomized keys, random re-pulsing
        for (int n = 0; n < 6; n++) begin
            run_expansion($sformatf("rand%0d", n), rand128(), 1'($urandom_range(0, 1)));
            sweep($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
